// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: register geometry,
// write-FSM state encoding and the hard-wired zero register.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // Plain-constant state encoding so older consumers can compare raw bits.
  typedef logic [0:0] wrState_t;
  localparam wrState_t IDLE  = 1'b0;
  localparam wrState_t WRITE = 1'b1;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-requester round-robin arbiter producing a one-hot grant; owns the
// "last granted" pointer used to break ties between simultaneous requests.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  // A tie goes to whichever port was not served most recently.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req0 && req1) begin
        grant = last ? 2'b01 : 2'b10;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the 32x32 register file (ALU port 0, load port 1).
// Define REGFILE_ARB_BYPASS_EN to add the rd_addr/fwd_hit/fwd_data forwarding path.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic [1:0]        grant;
  logic              arbEnable;
  logic              acceptAny;
  logic              acceptNonZero;
  logic [ADDR_W-1:0] acceptAddr;
  logic [DATA_W-1:0] acceptData;
  wrState_t          state;
  wrState_t          stateNext;

  assign arbEnable  = !rf_stall && rst_n;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign acceptAny  = |grant;

  rr_arbiter2 arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .enable  (arbEnable),
    .advance (acceptAny),
    .grant   (grant)
  );

  // Writes to r0 still complete the handshake but never reach the file.
  always_comb begin
    acceptAddr = req0_addr;
    acceptData = req0_data;
    if (grant[1]) begin
      acceptAddr = req1_addr;
      acceptData = req1_data;
    end
    acceptNonZero = acceptAny && (acceptAddr != ADDR_W'(ZERO_REG));
    stateNext     = acceptNonZero ? WRITE : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= stateNext;
      if (acceptNonZero) begin
        rf_waddr <= acceptAddr;
        rf_wdata <= acceptData;
      end
    end
  end

  assign rf_we = (state == WRITE);

`ifdef REGFILE_ARB_BYPASS_EN
  // Lets decode see a write the register file commits only at the next edge.
  assign fwd_hit  = rf_we && (rf_waddr == rd_addr) && (rd_addr != ADDR_W'(ZERO_REG));
  assign fwd_data = rf_wdata;
`else
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the single write port of the 32×32 register file between two writeback requesters: port 0 for ALU results and port 1 for memory load data. Each requester uses a valid/ready handshake. The block grants one accepted write per cycle using round-robin priority and drives a registered, one-cycle write strobe into the register file. Writes to register 0 are accepted and dropped, so r0 always reads zero.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has a write pending
- req0_ready / req1_ready  out  1  write accepted this cycle when valid&&ready
- req0_addr / req1_addr  in  ADDR_W  destination register
- req0_data / req1_data  in  DATA_W  write data
- rf_stall  in  1  blocks new grants (pipeline freeze)
- rf_we  out  1  register-file write strobe
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data

## Operation
- FSM states:
  - IDLE: rf_we=0.
  - WRITE: rf_we=1.
- FSM transitions, evaluated every cycle:
  - An accepted write to a nonzero address moves to WRITE.
  - Otherwise the FSM moves to IDLE.
  - WRITE→WRITE gives back-to-back writes.
- Grant rules:
  - req_ready is combinational from req_valid, rf_stall and the priority pointer.
  - At most one ready is high per cycle.
  - Both ready outputs are 0 while rf_stall=1.
- Round-robin pointer `last`:
  - Reset value is 1, so port 0 wins the first contention.
  - With only one port valid, that port is granted.
  - With both ports valid, the port ≠ last is granted.
  - `last` updates on every accepted transfer, including writes to r0.
- Address 0:
  - The handshake completes as normal.
  - The FSM goes to IDLE, rf_we stays 0.
  - rf_waddr and rf_wdata are not updated.
- rf_waddr and rf_wdata hold their last written values while in IDLE.
- Requesters must hold addr and data stable while valid && !ready.
- The block only samples addr and data on the accepting edge.

## Timing
- Reset (rst_n=0 at a rising edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, `last`=1, FSM=IDLE.
  - While rst_n=0, req0_ready and req1_ready are forced to 0.
- Latency: a write accepted at edge N appears with rf_we=1 during cycle N→N+1. The register file commits it at edge N+1.
- Throughput: one write per cycle, sustained.
- rf_stall asserted while in WRITE: the in-flight write still completes (rf_we is not extended). Only new grants are blocked.
- Reset mid-operation: a pending rf_we is cleared at the reset edge and that write is lost. Requesters must re-issue it.
- Simultaneous valid from both ports plus rf_stall: no grant, and `last` is unchanged.

## Configuration
- Macro: REGFILE_ARB_BYPASS_EN.
- When defined, the block adds these ports:
  - rd_addr  in  ADDR_W
  - fwd_hit  out  1
  - fwd_data  out  DATA_W
- fwd_hit = rf_we && (rf_waddr == rd_addr) && (rd_addr != 0). This is combinational.
- fwd_data = rf_wdata.
- The bypass lets a decoder see a write that the register file has not yet committed.
- When undefined, these ports and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, NUM_REGS = 32
  - the FSM state typedef (IDLE, WRITE)
  - constant ZERO_REG = 5'd0
- Sub-module rr_arbiter2:
  - Inputs: two requests, an enable (!rf_stall && rst_n) and an advance strobe.
  - Outputs: a one-hot grant.
  - Owns the `last` pointer.
- The top level holds the FSM, the output registers and the optional bypass.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both ports valid → both ready=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- Single port: req0 writes r5=32'h0000_F0F0 → req0_ready=1 in that cycle. Next cycle shows rf_we=1, rf_waddr=5, rf_wdata=32'h0000_F0F0 for exactly one cycle.
- Contention: both ports valid for 4 cycles (req0 writing r1..r4, req1 writing r9..r12) → grants alternate 0,1,0,1 and rf_waddr sequence is 1,9,2,10.
- r0 write: req1 writes r0=32'hDEAD_BEEF → handshake completes, rf_we stays 0, rf_waddr is unchanged. The next contention is granted to port 0.
- Stall: assert rf_stall one cycle after an accept → the in-flight rf_we pulse still occurs, ready stays 0 for the whole stall, and the grant resumes the cycle after stall deasserts.
- Bypass (REGFILE_ARB_BYPASS_EN defined): rd_addr=7 while rf_we=1 and rf_waddr=7 → fwd_hit=1, fwd_data=rf_wdata. With rd_addr=0 or rf_we=0 → fwd_hit=0.
